// File: rtl/wb_stage_pipelined_pkg.sv
// Shared encodings for the write-back stage: load-size codes and halt-drain FSM states.
package wb_stage_pipelined_pkg;

  typedef logic [1:0] load_size_t;

  localparam load_size_t LOAD_SIZE_BYTE = 2'b00;
  localparam load_size_t LOAD_SIZE_HALF = 2'b01;
  localparam load_size_t LOAD_SIZE_WORD = 2'b10;
  localparam load_size_t LOAD_SIZE_FULL = 2'b11;

  typedef enum logic [1:0] {
    WB_ST_RUN    = 2'b00,
    WB_ST_DRAIN  = 2'b01,
    WB_ST_HALTED = 2'b10
  } wb_state_e;

endpackage

// File: rtl/wb_stage_pipelined_load_align.sv
// Combinational load aligner: picks the addressed byte/half/word lane out of the
// raw memory word and sign- or zero-extends it to the full datapath width.
module wb_stage_pipelined_load_align
  import wb_stage_pipelined_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OFF_W      = $clog2(DATA_WIDTH / 8)
) (
  input  logic [DATA_WIDTH-1:0] readData_i,
  input  logic [OFF_W-1:0]      offset_i,
  input  load_size_t            size_i,
  input  logic                  loadUnsigned_i,
  output logic [DATA_WIDTH-1:0] alignedData_o
);

  localparam logic [OFF_W-1:0] HALF_OFF_MASK = ~OFF_W'(1);
  localparam logic [OFF_W-1:0] WORD_OFF_MASK = ~OFF_W'(3);

  logic [OFF_W-1:0]      effOff;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] fieldMask;
  logic                  signBit;

  // Misaligned offsets are truncated to the natural alignment of the access size.
  always_comb begin
    effOff = offset_i;
    case (size_i)
      LOAD_SIZE_BYTE: effOff = offset_i;
      LOAD_SIZE_HALF: effOff = offset_i & HALF_OFF_MASK;
      LOAD_SIZE_WORD: effOff = offset_i & WORD_OFF_MASK;
      default:        effOff = '0;
    endcase
  end

  assign shifted = readData_i >> {effOff, 3'b000};

  // Select field width and the bit that drives sign extension.
  always_comb begin
    fieldMask = '1;
    signBit   = 1'b0;
    case (size_i)
      LOAD_SIZE_BYTE: begin
        fieldMask = DATA_WIDTH'(8'hFF);
        signBit   = shifted[7];
      end
      LOAD_SIZE_HALF: begin
        fieldMask = DATA_WIDTH'(16'hFFFF);
        signBit   = shifted[15];
      end
      LOAD_SIZE_WORD: begin
        fieldMask = DATA_WIDTH'(32'hFFFF_FFFF);
        signBit   = shifted[31];
      end
      default: begin
        fieldMask = '1;
        signBit   = 1'b0;
      end
    endcase
  end

  assign alignedData_o = (shifted & fieldMask)
                       | ({DATA_WIDTH{signBit & ~loadUnsigned_i}} & ~fieldMask);

endmodule

// File: rtl/wb_stage_pipelined.sv
// Write-back stage: registers the MEM/WB payload, aligns load data, drives the
// register-file write port and forwarding taps, counts retired instructions and
// runs the halt-drain FSM that reports halt only once the pipe has emptied.
module wb_stage_pipelined
  import wb_stage_pipelined_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_stall,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  input  logic [DATA_WIDTH-1:0] i_read_data,
  input  logic [REG_ADDR_W-1:0] i_write_register,
  input  logic                  i_reg_write,
  input  logic                  i_mem_to_reg,
  input  logic [1:0]            i_load_size,
  input  logic                  i_load_unsigned,
  input  logic                  i_is_halt,
  output logic [DATA_WIDTH-1:0] o_write_data,
  output logic [REG_ADDR_W-1:0] o_write_register,
  output logic                  o_reg_write,
  output logic                  o_halted,
  output logic [CNT_W-1:0]      o_retired_count
);

  localparam int OFF_W = $clog2(DATA_WIDTH / 8);

  logic                  valid_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] aluResult_q;
  logic [DATA_WIDTH-1:0] readData_q;
  logic [REG_ADDR_W-1:0] writeReg_q;
  logic                  regWrite_q;
  logic                  memToReg_q;
  load_size_t            loadSize_q;
  logic                  loadUnsigned_q;
  logic                  isHalt_q;

  wb_state_e             state_q;
  wb_state_e             state_d;
  logic [3:0]            drainCnt_q;
  logic [CNT_W-1:0]      retired_q;

  logic                  capture;
  logic                  fresh;
  logic [DATA_WIDTH-1:0] alignedData;

  // Capture only while running and not stalled; a payload is "fresh" until its first cycle in WB has passed.
  assign capture = (state_q == WB_ST_RUN) && !i_stall;
  assign fresh   = valid_q && !done_q;

  // Stage register plus the one-shot flag that stops a held payload from writing twice.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q        <= 1'b0;
      done_q         <= 1'b0;
      aluResult_q    <= '0;
      readData_q     <= '0;
      writeReg_q     <= '0;
      regWrite_q     <= 1'b0;
      memToReg_q     <= 1'b0;
      loadSize_q     <= LOAD_SIZE_BYTE;
      loadUnsigned_q <= 1'b0;
      isHalt_q       <= 1'b0;
    end else if (capture) begin
      valid_q        <= i_valid;
      done_q         <= 1'b0;
      aluResult_q    <= i_alu_result;
      readData_q     <= i_read_data;
      writeReg_q     <= i_write_register;
      regWrite_q     <= i_reg_write;
      memToReg_q     <= i_mem_to_reg;
      loadSize_q     <= i_load_size;
      loadUnsigned_q <= i_load_unsigned;
      isHalt_q       <= i_is_halt;
    end else begin
      done_q         <= done_q | valid_q;
    end
  end

  // Saturating count of payloads that spent their first cycle in WB (R0 targets and halt included).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retired_q <= '0;
    end else if (fresh && (retired_q != '1)) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WB_ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a captured halt starts the drain, an expired drain counter halts for good.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WB_ST_RUN:    if (capture && i_valid && i_is_halt) state_d = WB_ST_DRAIN;
      WB_ST_DRAIN:  if (drainCnt_q == 4'd0) state_d = WB_ST_HALTED;
      WB_ST_HALTED: state_d = WB_ST_HALTED;
      default:      state_d = WB_ST_RUN;
    endcase
  end

  // Drain counter loads on entry to DRAIN and counts down to zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drainCnt_q <= 4'd0;
    end else if ((state_q == WB_ST_RUN) && (state_d == WB_ST_DRAIN)) begin
      drainCnt_q <= 4'(DRAIN_CYCLES - 1);
    end else if ((state_q == WB_ST_DRAIN) && (drainCnt_q != 4'd0)) begin
      drainCnt_q <= drainCnt_q - 4'd1;
    end
  end

  wb_stage_pipelined_load_align #(
    .DATA_WIDTH(DATA_WIDTH),
    .OFF_W     (OFF_W)
  ) u_align (
    .readData_i    (readData_q),
    .offset_i      (aluResult_q[OFF_W-1:0]),
    .size_i        (loadSize_q),
    .loadUnsigned_i(loadUnsigned_q),
    .alignedData_o (alignedData)
  );

  // FSM and datapath outputs, driven only from registered state.
  always_comb begin
    o_write_data     = memToReg_q ? alignedData : aluResult_q;
    o_write_register = writeReg_q;
    o_reg_write      = fresh && regWrite_q && (writeReg_q != '0) && !isHalt_q
                       && (state_q != WB_ST_HALTED);
    o_halted         = (state_q == WB_ST_HALTED);
    o_retired_count  = retired_q;
  end

endmodule

// File: tb/tb_wb_stage_pipelined.sv
// Directed testbench for the write-back stage: load alignment, R0 suppression,
// stall one-shot, back-to-back writes, halt drain, reset mid-drain, counter saturation.
module tb_wb_stage_pipelined;

  localparam int DW    = 32;
  localparam int RW    = 5;
  localparam int CNT_W = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          i_stall = 1'b0;
  logic          i_valid = 1'b0;
  logic [DW-1:0] i_alu_result = '0;
  logic [DW-1:0] i_read_data = '0;
  logic [RW-1:0] i_write_register = '0;
  logic          i_reg_write = 1'b0;
  logic          i_mem_to_reg = 1'b0;
  logic [1:0]    i_load_size = 2'b00;
  logic          i_load_unsigned = 1'b0;
  logic          i_is_halt = 1'b0;
  logic [DW-1:0] o_write_data;
  logic [RW-1:0] o_write_register;
  logic          o_reg_write;
  logic          o_halted;
  logic [CNT_W-1:0] o_retired_count;

  int checks = 0;
  int fails  = 0;
  int expRetired = 0;

  wb_stage_pipelined #(
    .DATA_WIDTH  (DW),
    .REG_ADDR_W  (RW),
    .DRAIN_CYCLES(2),
    .CNT_W       (CNT_W)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_stall         (i_stall),
    .i_valid         (i_valid),
    .i_alu_result    (i_alu_result),
    .i_read_data     (i_read_data),
    .i_write_register(i_write_register),
    .i_reg_write     (i_reg_write),
    .i_mem_to_reg    (i_mem_to_reg),
    .i_load_size     (i_load_size),
    .i_load_unsigned (i_load_unsigned),
    .i_is_halt       (i_is_halt),
    .o_write_data    (o_write_data),
    .o_write_register(o_write_register),
    .o_reg_write     (o_reg_write),
    .o_halted        (o_halted),
    .o_retired_count (o_retired_count)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic logic [CNT_W-1:0] satCount(input int n);
    return (n > 15) ? 4'd15 : 4'(n);
  endfunction

  task automatic setOp(input logic v, input logic [DW-1:0] alu, input logic [DW-1:0] rdata,
                       input logic [RW-1:0] wreg, input logic rw, input logic m2r,
                       input logic [1:0] size, input logic uns, input logic halt);
    i_valid = v; i_alu_result = alu; i_read_data = rdata; i_write_register = wreg;
    i_reg_write = rw; i_mem_to_reg = m2r; i_load_size = size; i_load_unsigned = uns;
    i_is_halt = halt;
  endtask

  task automatic setIdle();
    setOp(1'b0, '0, '0, '0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #2;
    checks++; if (o_write_data !== 32'h0) begin fails++; $display("[TB] FAIL reset_data got %h expected 0", o_write_data); end
    checks++; if (o_write_register !== 5'd0) begin fails++; $display("[TB] FAIL reset_wreg got %0d expected 0", o_write_register); end
    checks++; if (o_reg_write !== 1'b0) begin fails++; $display("[TB] FAIL reset_regwrite got %b expected 0", o_reg_write); end
    checks++; if (o_halted !== 1'b0) begin fails++; $display("[TB] FAIL reset_halted got %b expected 0", o_halted); end
    checks++; if (o_retired_count !== 4'd0) begin fails++; $display("[TB] FAIL reset_count got %0d expected 0", o_retired_count); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    expRetired = 0;
  endtask

  task automatic test_load_byte();
    setOp(1'b1, 32'h0000_1003, 32'h80FF_1234, 5'd3, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    tick(); expRetired++;
    checks++; if (o_write_data !== 32'hFFFF_FF80) begin fails++; $display("[TB] FAIL lb_signed got %h expected ffffff80", o_write_data); end
    checks++; if (o_reg_write !== 1'b1) begin fails++; $display("[TB] FAIL lb_regwrite got %b expected 1", o_reg_write); end
    setOp(1'b1, 32'h0000_1003, 32'h80FF_1234, 5'd3, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0);
    tick(); expRetired++;
    checks++; if (o_write_data !== 32'h0000_0080) begin fails++; $display("[TB] FAIL lbu got %h expected 00000080", o_write_data); end
    setOp(1'b1, 32'h0000_0001, 32'h80FF_1234, 5'd3, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    tick(); expRetired++;
    checks++; if (o_write_data !== 32'h0000_0012) begin fails++; $display("[TB] FAIL lb_off1 got %h expected 00000012", o_write_data); end
  endtask

  task automatic test_load_half();
    setOp(1'b1, 32'h0000_0002, 32'h8001_7FFF, 5'd4, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    tick(); expRetired++;
    checks++; if (o_write_data !== 32'hFFFF_8001) begin fails++; $display("[TB] FAIL lh_off2 got %h expected ffff8001", o_write_data); end
    setOp(1'b1, 32'h0000_0000, 32'h8001_7FFF, 5'd4, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    tick(); expRetired++;
    checks++; if (o_write_data !== 32'h0000_7FFF) begin fails++; $display("[TB] FAIL lh_off0 got %h expected 00007fff", o_write_data); end
    setOp(1'b1, 32'h0000_0003, 32'h8001_7FFF, 5'd4, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    tick(); expRetired++;
    checks++; if (o_write_data !== 32'hFFFF_8001) begin fails++; $display("[TB] FAIL lh_misaligned got %h expected ffff8001", o_write_data); end
    setOp(1'b1, 32'h0000_0002, 32'h8001_7FFF, 5'd4, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0);
    tick(); expRetired++;
    checks++; if (o_write_data !== 32'h0000_8001) begin fails++; $display("[TB] FAIL lhu_off2 got %h expected 00008001", o_write_data); end
  endtask

  task automatic test_word_and_alu();
    setOp(1'b1, 32'h0000_0001, 32'h80FF_1234, 5'd6, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
    tick(); expRetired++;
    checks++; if (o_write_data !== 32'h80FF_1234) begin fails++; $display("[TB] FAIL lw got %h expected 80ff1234", o_write_data); end
    setOp(1'b1, 32'hDEAD_BEEF, 32'h1111_1111, 5'd7, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    tick(); expRetired++;
    checks++; if (o_write_data !== 32'hDEAD_BEEF) begin fails++; $display("[TB] FAIL alu_data got %h expected deadbeef", o_write_data); end
    checks++; if (o_write_register !== 5'd7) begin fails++; $display("[TB] FAIL alu_wreg got %0d expected 7", o_write_register); end
  endtask

  task automatic test_r0();
    setOp(1'b1, 32'h0000_0055, 32'h0, 5'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    tick(); expRetired++;
    checks++; if (o_reg_write !== 1'b0) begin fails++; $display("[TB] FAIL r0_regwrite got %b expected 0", o_reg_write); end
    checks++; if (o_write_data !== 32'h0000_0055) begin fails++; $display("[TB] FAIL r0_data got %h expected 00000055", o_write_data); end
    setIdle();
    tick();
    checks++; if (o_retired_count !== satCount(expRetired)) begin fails++; $display("[TB] FAIL r0_count got %0d expected %0d", o_retired_count, satCount(expRetired)); end
  endtask

  task automatic test_stall();
    int pulses = 0;
    setOp(1'b1, 32'h1234_5678, 32'h0, 5'd5, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    tick(); expRetired++;
    if (o_reg_write === 1'b1) pulses++;
    i_stall = 1'b1;
    setOp(1'b1, 32'h0000_AAAA, 32'h0, 5'd9, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      if (o_reg_write === 1'b1) pulses++;
    end
    checks++; if (pulses !== 1) begin fails++; $display("[TB] FAIL stall_pulses got %0d expected 1", pulses); end
    checks++; if (o_write_register !== 5'd5) begin fails++; $display("[TB] FAIL stall_wreg got %0d expected 5", o_write_register); end
    checks++; if (o_write_data !== 32'h1234_5678) begin fails++; $display("[TB] FAIL stall_data got %h expected 12345678", o_write_data); end
    i_stall = 1'b0;
    setIdle();
    tick();
    checks++; if (o_retired_count !== satCount(expRetired)) begin fails++; $display("[TB] FAIL stall_count got %0d expected %0d", o_retired_count, satCount(expRetired)); end
  endtask

  task automatic test_back_to_back();
    setOp(1'b1, 32'h0000_0011, 32'h0, 5'd1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    tick(); expRetired++;
    checks++; if ({o_reg_write, o_write_register} !== {1'b1, 5'd1}) begin fails++; $display("[TB] FAIL b2b_first got %b/%0d expected 1/1", o_reg_write, o_write_register); end
    setOp(1'b1, 32'h0000_0022, 32'h0, 5'd2, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    tick(); expRetired++;
    checks++; if ({o_reg_write, o_write_register} !== {1'b1, 5'd2}) begin fails++; $display("[TB] FAIL b2b_second got %b/%0d expected 1/2", o_reg_write, o_write_register); end
    checks++; if (o_write_data !== 32'h0000_0022) begin fails++; $display("[TB] FAIL b2b_data got %h expected 00000022", o_write_data); end
  endtask

  task automatic test_halt();
    setOp(1'b1, 32'h0000_0000, 32'h0, 5'd4, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
    tick(); expRetired++;
    checks++; if (o_reg_write !== 1'b0) begin fails++; $display("[TB] FAIL halt_nowrite got %b expected 0", o_reg_write); end
    checks++; if (o_halted !== 1'b0) begin fails++; $display("[TB] FAIL halt_early0 got %b expected 0", o_halted); end
    setOp(1'b1, 32'h0000_0077, 32'h0, 5'd7, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    tick();
    checks++; if (o_halted !== 1'b0) begin fails++; $display("[TB] FAIL halt_early1 got %b expected 0", o_halted); end
    checks++; if (o_reg_write !== 1'b0) begin fails++; $display("[TB] FAIL drain_regwrite got %b expected 0", o_reg_write); end
    tick();
    checks++; if (o_halted !== 1'b1) begin fails++; $display("[TB] FAIL halt_rise got %b expected 1", o_halted); end
    checks++; if (o_write_register !== 5'd4) begin fails++; $display("[TB] FAIL halt_ignore_wreg got %0d expected 4", o_write_register); end
    repeat (3) tick();
    checks++; if ({o_halted, o_reg_write} !== 2'b10) begin fails++; $display("[TB] FAIL halt_sticky got %b expected 10", {o_halted, o_reg_write}); end
    checks++; if (o_retired_count !== satCount(expRetired)) begin fails++; $display("[TB] FAIL halt_count got %0d expected %0d", o_retired_count, satCount(expRetired)); end
    setIdle();
  endtask

  task automatic test_reset_mid_drain();
    reset_n = 1'b0;
    #3;
    @(negedge clk);
    reset_n = 1'b1;
    expRetired = 0;
    setOp(1'b1, 32'h0000_0099, 32'h0, 5'd6, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
    tick(); expRetired++;
    checks++; if (o_write_data !== 32'h0000_0099) begin fails++; $display("[TB] FAIL drain_data got %h expected 00000099", o_write_data); end
    setIdle();
    #2 reset_n = 1'b0;
    #1;
    checks++; if (o_write_data !== 32'h0) begin fails++; $display("[TB] FAIL rst_drain_data got %h expected 0", o_write_data); end
    checks++; if (o_write_register !== 5'd0) begin fails++; $display("[TB] FAIL rst_drain_wreg got %0d expected 0", o_write_register); end
    checks++; if ({o_halted, o_reg_write} !== 2'b00) begin fails++; $display("[TB] FAIL rst_drain_flags got %b expected 00", {o_halted, o_reg_write}); end
    checks++; if (o_retired_count !== 4'd0) begin fails++; $display("[TB] FAIL rst_drain_count got %0d expected 0", o_retired_count); end
    @(negedge clk);
    reset_n = 1'b1;
    expRetired = 0;
    repeat (3) tick();
    checks++; if (o_halted !== 1'b0) begin fails++; $display("[TB] FAIL post_rst_halted got %b expected 0", o_halted); end
    checks++; if (o_retired_count !== 4'd0) begin fails++; $display("[TB] FAIL post_rst_count got %0d expected 0", o_retired_count); end
    setOp(1'b1, 32'h0000_0033, 32'h0, 5'd3, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    tick(); expRetired++;
    checks++; if (o_reg_write !== 1'b1) begin fails++; $display("[TB] FAIL post_rst_write got %b expected 1", o_reg_write); end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 20; k++) begin
      setOp(1'b1, 32'(k), 32'h0, 5'd1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
      tick(); expRetired++;
    end
    setIdle();
    tick();
    checks++; if (o_retired_count !== satCount(expRetired)) begin fails++; $display("[TB] FAIL saturate got %0d expected %0d", o_retired_count, satCount(expRetired)); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_load_byte();
    test_load_half();
    test_word_and_alu();
    test_r0();
    test_stall();
    test_back_to_back();
    test_halt();
    test_reset_mid_drain();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Watchdog so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

endmodule
